// File: rtl/bcd_pkg.sv
// Shared constants and 7-segment table for the serial BCD collector.
package bcd_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   // Segment order {g,f,e,d,c,b,a}, active high; non-BCD nibbles show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = 7'b0111111;
         4'd1:    seg = 7'b0000110;
         4'd2:    seg = 7'b1011011;
         4'd3:    seg = 7'b1001111;
         4'd4:    seg = 7'b1100110;
         4'd5:    seg = 7'b1101101;
         4'd6:    seg = 7'b1111101;
         4'd7:    seg = 7'b0000111;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1101111;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational nibble to 7-segment decode feeding the Seg register.
module bcd_seg_decoder
   import bcd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = seg_decode(nibble);

endmodule

// File: rtl/bcd_serial_collector.sv
// Reassembles LSB-first serial BCD groups into digits, keeps a digit history,
// a saturating count of legal digits and the 7-segment pattern of the last nibble.
module bcd_serial_collector
   import bcd_pkg::*;
#(
   parameter int NDIG = 4,
   parameter int CNTW = 8
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                Z,
   output logic [3:0]          Digit,
   output logic                DigitVld,
   output logic                DigitErr,
   output logic [6:0]          Seg,
   output logic [4*NDIG-1:0]   Digits,
   output logic [CNTW-1:0]     Count
);

   logic [1:0]        bit_idx;
   logic [2:0]        sh;
   logic [3:0]        nibble;
   logic              last_bit;
   logic              legal;
   logic [6:0]        seg_next;
   logic [4*NDIG-1:0] digits_next;

   assign last_bit = (bit_idx == 2'd3);
   assign nibble   = {Z, sh};
   assign legal    = (nibble <= BCD_MAX);

   bcd_seg_decoder u_seg_decoder (
      .nibble (nibble),
      .seg    (seg_next)
   );

   generate
      if (NDIG == 1) begin : g_hist_one
         assign digits_next = nibble;
      end else begin : g_hist_many
         assign digits_next = {Digits[4*NDIG-5:0], nibble};
      end
   endgenerate

   // The 4th bit is taken straight from Z, so the nibble completes on the same edge.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         bit_idx  <= 2'd0;
         sh       <= 3'd0;
         Digit    <= 4'd0;
         DigitVld <= 1'b0;
         DigitErr <= 1'b0;
         Seg      <= SEG_BLANK;
         Digits   <= '0;
         Count    <= '0;
      end else begin
         DigitVld <= 1'b0;
         DigitErr <= 1'b0;
         bit_idx  <= bit_idx + 2'd1;
         if (!last_bit) begin
            sh[bit_idx] <= Z;
         end else begin
            Digit <= nibble;
            Seg   <= seg_next;
            if (legal) begin
               DigitVld <= 1'b1;
               Digits   <= digits_next;
               if (Count != '1)
                  Count <= Count + CNTW'(1);
            end else begin
               DigitErr <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Directed bench for bcd_serial_collector: a default instance plus an NDIG=1, CNTW=2 instance.
module tb_bcd_serial_collector;

   logic        Clk;
   logic        Rst;
   logic        Z;

   logic [3:0]  digit_a;
   logic        vld_a, err_a;
   logic [6:0]  seg_a;
   logic [15:0] digits_a;
   logic [7:0]  count_a;

   logic [3:0]  digit_b;
   logic        vld_b, err_b;
   logic [6:0]  seg_b;
   logic [3:0]  digits_b;
   logic [1:0]  count_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bcd_serial_collector #(.NDIG(4), .CNTW(8)) dut_a (
      .Clk(Clk), .Rst(Rst), .Z(Z),
      .Digit(digit_a), .DigitVld(vld_a), .DigitErr(err_a),
      .Seg(seg_a), .Digits(digits_a), .Count(count_a)
   );

   bcd_serial_collector #(.NDIG(1), .CNTW(2)) dut_b (
      .Clk(Clk), .Rst(Rst), .Z(Z),
      .Digit(digit_b), .DigitVld(vld_b), .DigitErr(err_b),
      .Seg(seg_b), .Digits(digits_b), .Count(count_b)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Posedges since reset release; the first sampling edge is cycle 1.
   always @(posedge Clk or negedge Rst) begin
      if (!Rst) cyc = 0;
      else      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called away from posedge; returns at posedge+1.
   task automatic send_bit(input logic b);
      Z = b;
      @(posedge Clk);
      #1;
   endtask

   task automatic send_digit(input logic [3:0] n);
      for (int i = 0; i < 4; i++) send_bit(n[i]);
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      #1;
      chk("rst_digit",  {28'd0, digit_a},  32'd0);
      chk("rst_vld",    {31'd0, vld_a},    32'd0);
      chk("rst_err",    {31'd0, err_a},    32'd0);
      chk("rst_seg",    {25'd0, seg_a},    32'd0);
      chk("rst_digits", {16'd0, digits_a}, 32'd0);
      chk("rst_count",  {24'd0, count_a},  32'd0);
      chk("rst_count_b",{30'd0, count_b},  32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   initial begin
      Z   = 1'b0;
      Rst = 1'b0;
      do_reset();

      // Single digit 5.
      send_digit(4'd5);
      chk("d5_digit",  {28'd0, digit_a},  32'h5);
      chk("d5_vld",    {31'd0, vld_a},    32'd1);
      chk("d5_err",    {31'd0, err_a},    32'd0);
      chk("d5_seg",    {25'd0, seg_a},    32'b1101101);
      chk("d5_digits", {16'd0, digits_a}, 32'h0005);
      chk("d5_count",  {24'd0, count_a},  32'd1);
      send_bit(1'b0);
      chk("d5_vld_drop", {31'd0, vld_a}, 32'd0);

      // 9, 0, 3 after a fresh reset; pulses seen at cycles 5, 9, 13.
      do_reset();
      send_digit(4'd9);
      chk("s9_vld",  {31'd0, vld_a}, 32'd1);
      chk("s9_cyc",  cyc + 1,        32'd5);
      chk("s9_seg",  {25'd0, seg_a}, 32'b1101111);
      send_digit(4'd0);
      chk("s0_vld",  {31'd0, vld_a}, 32'd1);
      chk("s0_cyc",  cyc + 1,        32'd9);
      chk("s0_seg",  {25'd0, seg_a}, 32'b0111111);
      send_digit(4'd3);
      chk("s3_vld",    {31'd0, vld_a},    32'd1);
      chk("s3_cyc",    cyc + 1,           32'd13);
      chk("s3_seg",    {25'd0, seg_a},    32'b1001111);
      chk("s3_digits", {16'd0, digits_a}, 32'h0903);
      chk("s3_count",  {24'd0, count_a},  32'd3);

      // Illegal nibbles 10 and 15.
      send_digit(4'd10);
      chk("e10_err",    {31'd0, err_a},    32'd1);
      chk("e10_vld",    {31'd0, vld_a},    32'd0);
      chk("e10_digit",  {28'd0, digit_a},  32'hA);
      chk("e10_seg",    {25'd0, seg_a},    32'b1000000);
      chk("e10_digits", {16'd0, digits_a}, 32'h0903);
      chk("e10_count",  {24'd0, count_a},  32'd3);
      send_digit(4'd15);
      chk("e15_err",    {31'd0, err_a},    32'd1);
      chk("e15_digit",  {28'd0, digit_a},  32'hF);
      chk("e15_seg",    {25'd0, seg_a},    32'b1000000);
      chk("e15_digits", {16'd0, digits_a}, 32'h0903);
      chk("e15_count",  {24'd0, count_a},  32'd3);
      send_bit(1'b0);
      chk("e15_err_drop", {31'd0, err_a}, 32'd0);

      // Saturation on the CNTW=2 instance; NDIG=1 history holds the newest digit.
      do_reset();
      send_digit(4'd1);
      chk("sat1_count_b",  {30'd0, count_b},  32'd1);
      chk("sat1_digits_b", {28'd0, digits_b}, 32'h1);
      send_digit(4'd2);
      chk("sat2_count_b",  {30'd0, count_b},  32'd2);
      send_digit(4'd3);
      chk("sat3_count_b",  {30'd0, count_b},  32'd3);
      send_digit(4'd4);
      chk("sat4_count_b",  {30'd0, count_b},  32'd3);
      chk("sat4_digits_b", {28'd0, digits_b}, 32'h4);
      send_digit(4'd5);
      chk("sat5_count_b",  {30'd0, count_b},  32'd3);
      chk("sat5_digits_b", {28'd0, digits_b}, 32'h5);
      chk("sat5_digits_a", {16'd0, digits_a}, 32'h2345);
      chk("sat5_count_a",  {24'd0, count_a},  32'd5);

      // Reset after two bits of a group, then digit 4.
      send_bit(1'b1);
      send_bit(1'b1);
      do_reset();
      send_digit(4'd4);
      chk("mid_digit",  {28'd0, digit_a},  32'h4);
      chk("mid_vld",    {31'd0, vld_a},    32'd1);
      chk("mid_seg",    {25'd0, seg_a},    32'b1100110);
      chk("mid_count",  {24'd0, count_a},  32'd1);
      chk("mid_digits", {16'd0, digits_a}, 32'h0004);

      // Asynchronous reset while a pulse is up.
      send_digit(4'd7);
      chk("async_pre_vld", {31'd0, vld_a}, 32'd1);
      #2;
      Rst = 1'b0;
      #1;
      chk("async_vld",    {31'd0, vld_a},    32'd0);
      chk("async_seg",    {25'd0, seg_a},    32'd0);
      chk("async_digits", {16'd0, digits_a}, 32'd0);
      chk("async_count",  {24'd0, count_a},  32'd0);
      @(negedge Clk);
      Rst = 1'b1;

      // Reset held across the would-be completion edge: no pulse, no update.
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      Z = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      @(posedge Clk);
      #1;
      chk("rstwin_vld",   {31'd0, vld_a},   32'd0);
      chk("rstwin_count", {24'd0, count_a}, 32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      send_digit(4'd8);
      chk("after_digit", {28'd0, digit_a}, 32'h8);
      chk("after_seg",   {25'd0, seg_a},   32'b1111111);
      chk("after_count", {24'd0, count_a}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
